// File: rtl/maze_tile_renderer.sv
// Maze tile renderer: maps a scanned spot to a tile texel colour, with an animated tile bank.
// Fixed 4-cycle latency, one pixel per clock, never stalls; texel ROM answers one cycle after sprite_addr.
`timescale 1ns/1ps
module maze_tile_renderer #(
  parameter logic [23:0] BG_COLOR    = 24'h202020,
  parameter logic [23:0] TRANSP_KEY  = 24'hFF00FF,
  parameter int          ANIM_BASE   = 12,
  parameter int          ANIM_PERIOD = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic signed [10:0] spotX,
  input  logic signed [10:0] spotY,
  input  logic               active,
  input  logic               frame_start,
  input  logic [3:0]         wall_num,
  output logic [15:0]        sprite_addr,
  input  logic [23:0]        sprite_data,
  output logic [7:0]         R,
  output logic [7:0]         G,
  output logic [7:0]         B,
  output logic               pix_valid
);

  localparam logic [7:0] PERIOD_LAST = 8'(ANIM_PERIOD - 1);

  logic [4:0]  sx1_q, sy1_q;
  logic        act1_q, act2_q, act3_q;
  logic [3:0]  tile2_q, tile3_q;
  logic [15:0] addr_q, addr_d;
  logic [23:0] rgb_q, rgb_d;
  logic        pv_q, pv_d;
  logic [7:0]  frame_div_q, frame_div_d;
  logic [1:0]  anim_q, anim_d;
  logic        is_anim;

  // Only the low five coordinate bits address a texel within a 32x32 tile.
  logic unused_coord_hi;
  assign unused_coord_hi = ^{spotX[10:5], spotY[10:5]};

  always_comb begin
    frame_div_d = frame_div_q;
    anim_d      = anim_q;
    if (frame_start) begin
      if (frame_div_q == PERIOD_LAST) begin
        frame_div_d = 8'd0;
        anim_d      = anim_q + 2'd1;
      end else begin
        frame_div_d = frame_div_q + 8'd1;
      end
    end
  end

  assign is_anim = (int'({28'd0, wall_num}) >= ANIM_BASE);

  always_comb begin
    addr_d = {(is_anim ? anim_q : 2'b00), wall_num, sy1_q, sx1_q};
  end

  // Inactive wins over everything, then empty tile, then transparent texel.
  always_comb begin
    rgb_d = 24'd0;
    pv_d  = 1'b0;
    if (act3_q) begin
      pv_d = 1'b1;
      if (tile3_q == 4'd0 || sprite_data == TRANSP_KEY) begin
        rgb_d = BG_COLOR;
      end else begin
        rgb_d = sprite_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      act1_q      <= 1'b0;
      act2_q      <= 1'b0;
      act3_q      <= 1'b0;
      addr_q      <= 16'd0;
      rgb_q       <= 24'd0;
      pv_q        <= 1'b0;
      frame_div_q <= 8'd0;
      anim_q      <= 2'd0;
    end else begin
      act1_q      <= active;
      act2_q      <= act1_q;
      act3_q      <= act2_q;
      addr_q      <= addr_d;
      rgb_q       <= rgb_d;
      pv_q        <= pv_d;
      frame_div_q <= frame_div_d;
      anim_q      <= anim_d;
    end
  end

  // Payload registers carry no meaning without their valid flag, so they skip reset.
  always_ff @(posedge clk) begin
    sx1_q   <= spotX[4:0];
    sy1_q   <= spotY[4:0];
    tile2_q <= wall_num;
    tile3_q <= tile2_q;
  end

  assign sprite_addr = addr_q;
  assign R           = rgb_q[23:16];
  assign G           = rgb_q[15:8];
  assign B           = rgb_q[7:0];
  assign pix_valid   = pv_q;

endmodule
